// File: rtl/maxpool_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_pkg
// Description : Shared state encoding, per-channel size functions and width
//               helpers for the maxpool frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package maxpool_pkg;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_CLEAR  = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_STREAM = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_DRAIN  = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_DONE   = 3'd4;

    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE   = c_ST_IDLE,
        S_CLEAR  = c_ST_CLEAR,
        S_STREAM = c_ST_STREAM,
        S_DRAIN  = c_ST_DRAIN,
        S_DONE   = c_ST_DONE
    } state_t;

    // Ceiling log2; f_clog2(1) == 0.
    function automatic int f_clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Bits needed to hold any count in 0..max_count (at least one bit).
    function automatic int f_cnt_width(input int max_count);
        int w;
        w = f_clog2(max_count + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Input pixels per channel of a square feature map.
    function automatic int f_pix_per_ch(input int img_size);
        return img_size * img_size;
    endfunction

    // Pooled outputs per channel for a 2x2 window with stride 2.
    function automatic int f_out_per_ch(input int img_size);
        return (img_size / 2) * (img_size / 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_frame_sequencer_if
// Description : Pixel source, pooling engine and pooled-output streams seen
//               by the frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface maxpool_frame_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    // Upstream pixel stream
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_ready;
    // Pooling engine
    logic                  pool_valid_in;
    logic [DATA_WIDTH-1:0] pool_data_in;
    logic                  pool_rst;
    logic                  pool_valid_out;
    logic [DATA_WIDTH-1:0] pool_data_out;
    // Downstream pooled stream
    logic                  dst_valid;
    logic [DATA_WIDTH-1:0] dst_data;
    logic                  dst_ready;

    modport master (
        input  src_valid, src_data, pool_valid_out, pool_data_out, dst_ready,
        output src_ready, pool_valid_in, pool_data_in, pool_rst, dst_valid, dst_data
    );

    modport slave (
        output src_valid, src_data, pool_valid_out, pool_data_out, dst_ready,
        input  src_ready, pool_valid_in, pool_data_in, pool_rst, dst_valid, dst_data
    );
endinterface
`default_nettype wire

// File: rtl/maxpool_frame_sequencer_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_out_reg
// Description : One-entry output register. Captures an engine result, holds
//               it until downstream accepts, and allows capture and release
//               in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_out_reg
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_capture,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_dst_ready,
    output logic                  o_dst_valid,
    output logic [DATA_WIDTH-1:0] o_dst_data
);

    logic                  r_dst_valid;
    logic [DATA_WIDTH-1:0] r_dst_data;

    // Capture wins over release so a same-cycle handoff keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dst_valid <= 1'b0;
            r_dst_data  <= '0;
        end else if (i_capture) begin
            r_dst_valid <= 1'b1;
            r_dst_data  <= i_data;
        end else if (r_dst_valid && i_dst_ready) begin
            r_dst_valid <= 1'b0;
        end
    end

    // Upstream gating must never let a result land on a stalled entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(i_capture && r_dst_valid && !i_dst_ready));
        end
    end

    assign o_dst_valid = r_dst_valid;
    assign o_dst_data  = r_dst_data;

endmodule
`default_nettype wire

// File: rtl/maxpool_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : maxpool_frame_sequencer
// Description : Sequences whole feature maps, channel by channel, through a
//               2x2/stride-2 maxpool engine, with upstream/downstream
//               valid/ready flow control and busy/done reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool_frame_sequencer
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 416,   // even, >= 4
    parameter int CH_WIDTH   = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CH_WIDTH-1:0] num_channels,
    output logic                busy,
    output logic                done,
    maxpool_frame_sequencer_if.master bus
);

    localparam int c_PIX_PER_CH = f_pix_per_ch(IMG_SIZE);
    localparam int c_OUT_PER_CH = f_out_per_ch(IMG_SIZE);
    localparam int c_PIX_W      = f_cnt_width(c_PIX_PER_CH - 1);
    localparam int c_OUT_W      = f_cnt_width(c_OUT_PER_CH);

    localparam logic [c_PIX_W-1:0] c_PIX_LAST  = c_PIX_W'(c_PIX_PER_CH - 1);
    localparam logic [c_OUT_W-1:0] c_OUT_TOTAL = c_OUT_W'(c_OUT_PER_CH);

    state_t                r_state;
    state_t                w_state_next;
    logic [CH_WIDTH-1:0]   r_channels;
    logic [CH_WIDTH-1:0]   r_ch_cnt;
    logic                  r_clr_cnt;
    logic [c_PIX_W-1:0]    r_pix_cnt;
    logic [c_OUT_W-1:0]    r_out_cnt;
    logic                  r_acc_d;

    logic                  w_src_ready;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_pool_rst;
    logic                  w_last_pix;
    logic                  w_drain_ok;
    logic                  w_last_ch;
    logic [CH_WIDTH:0]     w_ch_inc;
    logic                  w_dst_valid;
    logic [DATA_WIDTH-1:0] w_dst_data;

    // Pixels flow only while streaming and the output slot can take a result.
    assign w_src_ready = (r_state == S_STREAM) & (~w_dst_valid | bus.dst_ready);
    assign w_accept    = bus.src_valid & w_src_ready;
    // Engine valid_out is sticky between inputs, so only trust it right after one.
    assign w_capture   = r_acc_d & bus.pool_valid_out;
    assign w_pool_rst  = (r_state == S_IDLE) | (r_state == S_CLEAR);
    assign w_last_pix  = (r_pix_cnt == c_PIX_LAST);
    assign w_drain_ok  = (r_out_cnt == c_OUT_TOTAL) & ~w_dst_valid;
    assign w_ch_inc    = {1'b0, r_ch_cnt} + (CH_WIDTH + 1)'(1);
    assign w_last_ch   = (w_ch_inc == {1'b0, r_channels});

    assign bus.src_ready     = w_src_ready;
    assign bus.pool_valid_in = w_accept;
    assign bus.pool_data_in  = bus.src_data;
    assign bus.pool_rst      = w_pool_rst;
    assign bus.dst_valid     = w_dst_valid;
    assign bus.dst_data      = w_dst_data;

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_accept && w_last_pix) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_ok) begin
                    w_state_next = w_last_ch ? S_DONE : S_CLEAR;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Frame bookkeeping: channel, clear, pixel and output counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_channels <= '0;
            r_ch_cnt   <= '0;
            r_clr_cnt  <= 1'b0;
            r_pix_cnt  <= '0;
            r_out_cnt  <= '0;
            r_acc_d    <= 1'b0;
        end else begin
            r_acc_d   <= w_accept;
            r_clr_cnt <= (r_state == S_CLEAR) ? ~r_clr_cnt : 1'b0;

            if ((r_state == S_IDLE) && start) begin
                r_channels <= (num_channels == '0) ? CH_WIDTH'(1) : num_channels;
                r_ch_cnt   <= '0;
            end

            if (r_state == S_CLEAR) begin
                r_pix_cnt <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_accept) begin
                    r_pix_cnt <= r_pix_cnt + c_PIX_W'(1);
                end
                if (w_capture) begin
                    r_out_cnt <= r_out_cnt + c_OUT_W'(1);
                end
            end

            if ((r_state == S_DRAIN) && w_drain_ok) begin
                r_ch_cnt <= r_ch_cnt + CH_WIDTH'(1);
            end
        end
    end

    maxpool_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .i_capture   (w_capture),
        .i_data      (bus.pool_data_out),
        .i_dst_ready (bus.dst_ready),
        .o_dst_valid (w_dst_valid),
        .o_dst_data  (w_dst_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_maxpool_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_maxpool_frame_sequencer
// Description : Self-checking bench for maxpool_frame_sequencer with a
//               behavioural pooling engine and a window-max reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_maxpool_frame_sequencer;

    localparam int DW  = 32;
    localparam int IMG = 4;
    localparam int CHW = 10;
    localparam int PIX = IMG * IMG;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [CHW-1:0] num_channels;
    logic           busy;
    logic           done;

    maxpool_frame_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    maxpool_frame_sequencer #(
        .DATA_WIDTH (DW),
        .IMG_SIZE   (IMG),
        .CH_WIDTH   (CHW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_channels (num_channels),
        .busy         (busy),
        .done         (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pooling engine: output registered on the input that completes a window,
    // valid_out held unchanged between inputs.
    logic [DW-1:0] eng_pix [PIX];
    int            eng_cnt;

    always @(posedge clk) begin : engine_model
        int            r;
        int            c;
        logic [DW-1:0] m;
        if (bus.pool_rst) begin
            eng_cnt            <= 0;
            bus.pool_valid_out <= 1'b0;
            bus.pool_data_out  <= '0;
        end else if (bus.pool_valid_in && eng_cnt < PIX) begin
            r = eng_cnt / IMG;
            c = eng_cnt % IMG;
            eng_pix[eng_cnt] <= bus.pool_data_in;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                m = bus.pool_data_in;
                if (eng_pix[eng_cnt-1] > m)       m = eng_pix[eng_cnt-1];
                if (eng_pix[eng_cnt-IMG] > m)     m = eng_pix[eng_cnt-IMG];
                if (eng_pix[eng_cnt-IMG-1] > m)   m = eng_pix[eng_cnt-IMG-1];
                bus.pool_valid_out <= 1'b1;
                bus.pool_data_out  <= m;
            end else begin
                bus.pool_valid_out <= 1'b0;
            end
            eng_cnt <= eng_cnt + 1;
        end
    end

    logic [DW-1:0] pix_q [$];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] obs_q [$];
    int            g_rst_runs [$];
    int            g_done_cnt;
    int            g_accepted;
    int            g_timeout;
    int            g_busy_after;
    int            g_bp_viol;
    int            g_stall_hold;

    // Reference: pixel stream plus the max of every 2x2 window, row-major.
    task automatic build_frame(input int nch, input bit rnd);
        logic [DW-1:0] img [PIX];
        logic [DW-1:0] m;
        int            idx;
        pix_q.delete();
        exp_q.delete();
        for (int c = 0; c < nch; c++) begin
            for (int i = 0; i < PIX; i++) begin
                img[i] = rnd ? DW'($urandom) : DW'(PIX * c + i);
                pix_q.push_back(img[i]);
            end
            for (int wr = 0; wr < IMG / 2; wr++) begin
                for (int wc = 0; wc < IMG / 2; wc++) begin
                    m = '0;
                    for (int dr = 0; dr < 2; dr++) begin
                        for (int dc = 0; dc < 2; dc++) begin
                            idx = (2 * wr + dr) * IMG + 2 * wc + dc;
                            if (img[idx] > m) m = img[idx];
                        end
                    end
                    exp_q.push_back(m);
                end
            end
        end
    endtask

    // Drives one command and the pixel stream, records what leaves the DUT.
    // ready_mode: 0 always ready, 1 random, 2 stalled for cycles 8..27.
    task automatic run_frame(input int cmd_ch, input int valid_pct, input int ready_mode,
                             input int abort_at, input int restart_at);
        int cyc;
        int run;
        int done_at;
        bit fin;
        cyc = 0; run = 0; done_at = -1; fin = 1'b0;
        obs_q.delete();
        g_rst_runs.delete();
        g_done_cnt = 0; g_accepted = 0; g_timeout = 0; g_busy_after = 1;
        g_bp_viol = 0; g_stall_hold = 0;
        while (!fin) begin
            @(negedge clk);
            if (abort_at >= 0 && g_accepted == abort_at) begin
                bus.src_valid = 1'b0;
                start = 1'b0;
                return;
            end
            start        = (cyc == 0) || (cyc == restart_at);
            num_channels = (cyc == 0) ? CHW'(cmd_ch) : CHW'(3);
            bus.src_valid = (pix_q.size() > 0) && ($urandom_range(99) < valid_pct);
            bus.src_data  = (pix_q.size() > 0) ? pix_q[0] : '0;
            case (ready_mode)
                1:       bus.dst_ready = 1'($urandom_range(1));
                2:       bus.dst_ready = !(cyc >= 8 && cyc < 28);
                default: bus.dst_ready = 1'b1;
            endcase
            #1;
            if (bus.dst_valid && !bus.dst_ready && bus.src_ready) g_bp_viol++;
            if (ready_mode == 2 && cyc >= 8 && cyc < 28 && bus.dst_valid && !bus.src_ready)
                g_stall_hold++;
            if (bus.src_valid && bus.src_ready) begin
                void'(pix_q.pop_front());
                g_accepted++;
            end
            if (bus.dst_valid && bus.dst_ready) obs_q.push_back(bus.dst_data);
            if (busy && bus.pool_rst) begin
                run++;
            end else if (run > 0) begin
                g_rst_runs.push_back(run);
                run = 0;
            end
            if (done) begin
                g_done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (done_at >= 0 && cyc == done_at + 1) g_busy_after = int'(busy);
            if (done_at >= 0 && cyc == done_at + 4) fin = 1'b1;
            cyc++;
            if (cyc > 3000) begin
                g_timeout = 1;
                fin = 1'b1;
            end
        end
        start = 1'b0;
        bus.src_valid = 1'b0;
        bus.dst_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_tests++; if (bus.src_ready !== 1'b0) begin n_fail++; $display("FAIL reset_src_ready: got %b expected 0", bus.src_ready); end
        n_tests++; if (bus.pool_valid_in !== 1'b0) begin n_fail++; $display("FAIL reset_pool_valid_in: got %b expected 0", bus.pool_valid_in); end
        n_tests++; if (bus.pool_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pool_rst: got %b expected 1", bus.pool_rst); end
        n_tests++; if (bus.dst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dst_valid: got %b expected 0", bus.dst_valid); end
        n_tests++; if (bus.dst_data !== '0) begin n_fail++; $display("FAIL reset_dst_data: got %h expected 0", bus.dst_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_channel();
        build_frame(1, 1'b0);
        run_frame(1, 100, 0, -1, -1);
        n_tests++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL single_count: got %0d expected 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        n_tests++; if (g_done_cnt != 1) begin n_fail++; $display("FAIL single_done: got %0d pulses expected 1", g_done_cnt); end
        n_tests++; if (g_busy_after != 0) begin n_fail++; $display("FAIL single_busy_after: got %0d expected 0", g_busy_after); end
    endtask

    task automatic test_multi_channel();
        build_frame(3, 1'b0);
        run_frame(3, 100, 0, -1, -1);
        n_tests++; if (obs_q.size() != 12) begin n_fail++; $display("FAIL multi_count: got %0d expected 12", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL multi_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        n_tests++;
        if (obs_q.size() == 0 || obs_q[obs_q.size()-1] !== DW'(47)) begin
            n_fail++; $display("FAIL multi_last: got %h expected 2f", (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 'x);
        end
        n_tests++; if (g_rst_runs.size() != 3) begin n_fail++; $display("FAIL multi_rst_runs: got %0d runs expected 3", g_rst_runs.size()); end
        foreach (g_rst_runs[i]) begin
            n_tests++;
            if (g_rst_runs[i] != 2) begin n_fail++; $display("FAIL multi_rst_len[%0d]: got %0d expected 2", i, g_rst_runs[i]); end
        end
        n_tests++; if (g_done_cnt != 1) begin n_fail++; $display("FAIL multi_done: got %0d pulses expected 1", g_done_cnt); end
    endtask

    task automatic test_backpressure();
        build_frame(2, 1'b1);
        run_frame(2, 100, 2, -1, -1);
        n_tests++; if (g_accepted != 2 * PIX) begin n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", g_accepted, 2 * PIX); end
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        n_tests++; if (g_bp_viol != 0) begin n_fail++; $display("FAIL bp_src_ready_while_full: got %0d cycles expected 0", g_bp_viol); end
        n_tests++; if (g_stall_hold < 10) begin n_fail++; $display("FAIL bp_stall_hold: got %0d cycles expected >= 10", g_stall_hold); end
        n_tests++; if (g_done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1", g_done_cnt); end
    endtask

    task automatic test_random_gaps();
        build_frame(2, 1'b1);
        run_frame(2, 50, 0, -1, -1);
        n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL gaps_count: got %0d expected 8", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gaps_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        n_tests++; if (g_done_cnt != 1) begin n_fail++; $display("FAIL gaps_done: got %0d pulses expected 1", g_done_cnt); end
    endtask

    task automatic test_back_to_back();
        build_frame(2, 1'b1);
        run_frame(2, 80, 1, -1, -1);
        n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        n_tests++; if (g_bp_viol != 0) begin n_fail++; $display("FAIL b2b_src_ready_while_full: got %0d cycles expected 0", g_bp_viol); end
    endtask

    task automatic test_rst_mid_frame();
        build_frame(1, 1'b0);
        run_frame(1, 100, 0, 9, -1);
        rst = 1'b1;
        bus.dst_ready = 1'b0;
        n_tests++; if (g_accepted != 9) begin n_fail++; $display("FAIL rst_abort_point: got %0d pixels expected 9", g_accepted); end
        @(negedge clk);
        #1;
        n_tests++; if (bus.dst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dst_valid: got %b expected 0", bus.dst_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_tests++; if (bus.pool_rst !== 1'b1) begin n_fail++; $display("FAIL rst_pool_rst: got %b expected 1", bus.pool_rst); end
        n_tests++; if (bus.src_ready !== 1'b0) begin n_fail++; $display("FAIL rst_src_ready: got %b expected 0", bus.src_ready); end
        @(negedge clk);
        rst = 1'b0;
        bus.dst_ready = 1'b1;
        build_frame(1, 1'b0);
        run_frame(1, 100, 0, -1, -1);
        n_tests++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL rst_restart_count: got %0d expected 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rst_restart_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        build_frame(1, 1'b0);
        run_frame(0, 100, 0, -1, 10);
        n_tests++; if (g_timeout != 0) begin n_fail++; $display("FAIL zero_ch_timeout: got timeout expected done"); end
        n_tests++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL zero_ch_count: got %0d expected 4", obs_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL zero_ch_out[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
            end
        end
        n_tests++; if (g_rst_runs.size() != 1) begin n_fail++; $display("FAIL zero_ch_channels: got %0d expected 1", g_rst_runs.size()); end
        n_tests++; if (g_done_cnt != 1) begin n_fail++; $display("FAIL zero_ch_done: got %0d pulses expected 1", g_done_cnt); end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        num_channels  = '0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.dst_ready = 1'b1;

        test_reset();
        test_single_channel();
        test_multi_channel();
        test_backpressure();
        test_random_gaps();
        test_back_to_back();
        test_rst_mid_frame();
        test_start_while_busy();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
